// File: rtl/sklansky_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : sklansky_bist_if
//  Description : Operand/result bus between the BIST engine and the
//                combinational adder under test. The BIST side (master)
//                drives the operands and carry-in and observes the sum
//                and carry-out; the adder side (slave) is the reverse.
//
//  Signals     : dut_A    [WIDTH-1:0]  operand A       (master -> slave)
//                dut_B    [WIDTH-1:0]  operand B       (master -> slave)
//                dut_Cin               carry-in        (master -> slave)
//                dut_Sum  [WIDTH-1:0]  adder sum       (slave -> master)
//                dut_Cout              adder carry-out (slave -> master)
//
//  Revision    : 1.0  initial release
// ============================================================================
interface sklansky_bist_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] dut_A;
    logic [WIDTH-1:0] dut_B;
    logic             dut_Cin;
    logic [WIDTH-1:0] dut_Sum;
    logic             dut_Cout;

    // BIST engine side
    modport master (
        output dut_A,
        output dut_B,
        output dut_Cin,
        input  dut_Sum,
        input  dut_Cout
    );

    // Adder-under-test side
    modport slave (
        input  dut_A,
        input  dut_B,
        input  dut_Cin,
        output dut_Sum,
        output dut_Cout
    );

endinterface : sklansky_bist_if
`default_nettype wire

// File: rtl/sklansky_bist.sv
`default_nettype none
// ============================================================================
//  Module      : sklansky_adder
//  Description : Combinational WIDTH-bit Sklansky (divide-and-conquer)
//                parallel-prefix adder. The carry-in is folded into the
//                bit-0 generate term, so the group generate spanning bits
//                [i:0] is directly the carry out of bit i.
//
//  Ports       : a_i    [WIDTH-1:0]  operand A
//                b_i    [WIDTH-1:0]  operand B
//                cin_i               carry-in
//                sum_o  [WIDTH-1:0]  sum
//                cout_o              carry-out
//
//  Revision    : 1.0  initial release
// ============================================================================
module sklansky_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int LEVELS = $clog2(WIDTH);

    // Level 0 holds per-bit generate/propagate; level l holds the prefix
    // after merging blocks of size 2^l.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;

        if (l == 0) begin : g_init
            assign g = {a_i[WIDTH-1:1] & b_i[WIDTH-1:1],
                        (a_i[0] & b_i[0]) | ((a_i[0] ^ b_i[0]) & cin_i)};
            assign p = a_i ^ b_i;
        end else begin : g_tree
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (((i >> (l - 1)) & 1) == 1) begin : g_merge
                    // Upper half of a 2^l block: combine with the most
                    // significant bit of the lower half (Sklansky fan-out).
                    localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
                    assign g[i] = g_lvl[l-1].g[i] |
                                  (g_lvl[l-1].p[i] & g_lvl[l-1].g[J]);
                    assign p[i] = g_lvl[l-1].p[i] & g_lvl[l-1].p[J];
                end else begin : g_pass
                    assign g[i] = g_lvl[l-1].g[i];
                    assign p[i] = g_lvl[l-1].p[i];
                end
            end
        end
    end

    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;

    // Carry into bit i is the group generate of bits [i-1:0].
    assign w_carry    = {g_lvl[LEVELS].g[WIDTH-2:0], cin_i};
    assign sum_o      = g_lvl[0].p ^ w_carry;
    assign cout_o     = g_lvl[LEVELS].g[WIDTH-1];

    // The final-level group propagates have no consumer.
    assign w_unused_p = &g_lvl[LEVELS].p;

endmodule : sklansky_adder

// ============================================================================
//  Module      : sklansky_bist
//  Description : Built-in self-test engine for a combinational WIDTH-bit
//                adder. Sweeps every {A,B,Cin} vector exhaustively, checks
//                each adder response against a behavioural reference sum
//                and reports pass/fail, the error count and the index of the
//                first failing vector.
//
//  Ports       : clk                         rising-edge clock
//                rst                         synchronous active-high reset
//                start_i                     begin a sweep (IDLE/DONE only)
//                pause_i                     freeze sweep while high
//                bist_bus  (master modport)  operands out / results in
//                busy_o                      sweep in progress
//                done_o                      sweep complete, results valid
//                pass_o                      done with zero errors
//                err_count_o [2*WIDTH+1:0]   mismatching vector count
//                first_fail_o[2*WIDTH:0]     {A,B,Cin} of first mismatch
//                fail_seen_o                 any mismatch this sweep
//
//  Revision    : 1.0  initial release
// ============================================================================
module sklansky_bist #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   pause_i,
    sklansky_bist_if.master        bist_bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [2*WIDTH+1:0]     err_count_o,
    output logic [2*WIDTH:0]       first_fail_o,
    output logic                   fail_seen_o
);

    localparam int VEC_W = 2 * WIDTH + 1;
    localparam int ERR_W = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [VEC_W-1:0]   first_fail_q, first_fail_d;
    logic               fail_seen_q, fail_seen_d;

    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic               w_op_cin;
    logic [WIDTH:0]     w_ref;
    logic               w_mismatch;

    // ------------------------------------------------------------------
    // Drive mapping: {A, B, Cin} = vec, straight from the register so the
    // adder sees glitch-free operands for the whole cycle.
    // ------------------------------------------------------------------
    assign w_op_a   = vec_q[VEC_W-1 -: WIDTH];
    assign w_op_b   = vec_q[WIDTH:1];
    assign w_op_cin = vec_q[0];

    assign bist_bus.dut_A   = w_op_a;
    assign bist_bus.dut_B   = w_op_b;
    assign bist_bus.dut_Cin = w_op_cin;

    // Behavioural reference, one bit wider than the operands so the top
    // bit is the expected carry-out.
    assign w_ref = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_op_cin};

    // The adder is purely combinational, so its response to the vector
    // currently driven is checked in the same cycle.
    assign w_mismatch = ({bist_bus.dut_Cout, bist_bus.dut_Sum} != w_ref);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // A fresh sweep always starts from a clean result set; the
                // previous results stay visible in DONE until then.
                if (start_i) begin
                    state_d      = S_RUN;
                    vec_d        = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                end
            end

            S_RUN: begin
                // While paused nothing moves: no compare, no advance.
                if (!pause_i) begin
                    if (w_mismatch) begin
                        // Cannot wrap: at most 2^VEC_W errors fit ERR_W bits.
                        err_count_d = err_count_q + ERR_W'(1);
                        if (!fail_seen_q) begin
                            first_fail_d = vec_q;
                            fail_seen_d  = 1'b1;
                        end
                    end
                    // The last vector is compared on the same edge that
                    // enters DONE; vec is left on it so the drive holds.
                    if (&vec_q) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = (state_q == S_DONE) && (err_count_q == '0);
    assign err_count_o  = err_count_q;
    assign first_fail_o = first_fail_q;
    assign fail_seen_o  = fail_seen_q;

endmodule : sklansky_bist
`default_nettype wire
